// File: rtl/deco_scan.sv
// rtl/deco_scan.sv - registered N-to-2^N one-hot decoder with direct and auto-scan modes
module deco_scan #(
    parameter int W     = 4,
    parameter int DIV_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      in,
    input  logic              ena,
    input  logic              enb,
    input  logic              enc,
    input  logic              mode,
    input  logic              load,
    input  logic [DIV_W-1:0]  dwell,
    input  logic [W-1:0]      last,
    output logic [(1<<W)-1:0] out,
    output logic [W-1:0]      idx,
    output logic              wrap,
    output logic              active
);

    localparam int N = 1 << W;

    logic             en;
    logic [DIV_W-1:0] dcnt;
    logic [DIV_W-1:0] nxt_dcnt;
    logic [W-1:0]     nxt_idx;
    logic             nxt_wrap;
    logic [N-1:0]     nxt_out;

    assign en = ena & enb & ~enc;

    // Priority in scan mode: load, then step, then count.
    always_comb begin
        nxt_idx  = idx;
        nxt_dcnt = '0;
        nxt_wrap = 1'b0;
        nxt_out  = '0;
        if (en) begin
            if (!mode) begin
                nxt_idx = in;
            end else if (load) begin
                nxt_idx = in;
            end else if (dcnt == dwell) begin
                if (idx >= last) begin
                    nxt_idx  = '0;
                    nxt_wrap = 1'b1;
                end else begin
                    nxt_idx = idx + 1'b1;
                end
            end else begin
                nxt_dcnt = dcnt + 1'b1;
            end
            nxt_out[nxt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out    <= '0;
            idx    <= '0;
            dcnt   <= '0;
            wrap   <= 1'b0;
            active <= 1'b0;
        end else begin
            out    <= nxt_out;
            idx    <= nxt_idx;
            dcnt   <= nxt_dcnt;
            wrap   <= nxt_wrap;
            active <= en;
        end
    end

endmodule

// File: tb/tb_deco_scan.sv
// tb/tb_deco_scan.sv - directed self-checking bench for deco_scan
module tb_deco_scan;

    localparam int W     = 4;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     in;
    logic             ena, enb, enc, mode, load;
    logic [DIV_W-1:0] dwell;
    logic [W-1:0]     last;
    logic [15:0]      out;
    logic [W-1:0]     idx;
    logic             wrap, active;

    int n_tests = 0;
    int n_fail  = 0;

    deco_scan #(.W(W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .ena(ena), .enb(enb), .enc(enc),
        .mode(mode), .load(load), .dwell(dwell), .last(last),
        .out(out), .idx(idx), .wrap(wrap), .active(active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    int          scan_idx [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
    logic [31:0] one;

    initial begin
        one   = 32'd1;
        rst_n = 1'b0;
        in = '0; ena = 0; enb = 0; enc = 0; mode = 0; load = 0;
        dwell = '0; last = '0;
        #3;
        check("rst_out", 32'(out), 32'h0);
        check("rst_idx", 32'(idx), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        cyc(); cyc();
        rst_n = 1'b1;

        // direct sweep
        ena = 1; enb = 1; enc = 0; mode = 0;
        for (int i = 0; i < 16; i++) begin
            in = 4'(i);
            cyc();
            check("dir_out", 32'(out), one << i);
            check("dir_idx", 32'(idx), 32'(i));
            check("dir_active", 32'(active), 32'h1);
        end

        // enable gating
        in = 4'd5; cyc();
        check("gate_on", 32'(out), 32'h20);
        enc = 1; cyc();
        check("gate_enc_out", 32'(out), 32'h0);
        check("gate_enc_act", 32'(active), 32'h0);
        check("gate_enc_idx", 32'(idx), 32'h5);
        enc = 0; cyc();
        check("gate_back", 32'(out), 32'h20);
        ena = 0; cyc();
        check("gate_ena_out", 32'(out), 32'h0);
        check("gate_ena_idx", 32'(idx), 32'h5);
        ena = 1; cyc();
        check("gate_back2", 32'(out), 32'h20);

        // scan with dwell
        mode = 1; dwell = 8'd2; last = 4'd3; load = 1; in = 4'd0;
        for (int i = 0; i < 13; i++) begin
            cyc();
            load = 0;
            check("scan_idx", 32'(idx), 32'(scan_idx[i]));
            check("scan_out", 32'(out), one << scan_idx[i]);
            check("scan_wrap", 32'(wrap), (i == 12) ? 32'h1 : 32'h0);
        end

        // asynchronous reset between edges, mid-scan
        #2 rst_n = 1'b0;
        #1;
        check("mrst_out", 32'(out), 32'h0);
        check("mrst_idx", 32'(idx), 32'h0);
        check("mrst_wrap", 32'(wrap), 32'h0);
        check("mrst_active", 32'(active), 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("mrst_resume_idx", 32'(idx), 32'h0);
        check("mrst_resume_out", 32'(out), 32'h1);

        // load beyond last
        dwell = 8'd0; last = 4'd3; load = 1; in = 4'd9;
        cyc();
        load = 0;
        check("big_out", 32'(out), 32'h200);
        check("big_wrap0", 32'(wrap), 32'h0);
        cyc();
        check("big_wrap_out", 32'(out), 32'h1);
        check("big_wrap", 32'(wrap), 32'h1);
        cyc();
        check("big_next_out", 32'(out), 32'h2);
        check("big_next_wrap", 32'(wrap), 32'h0);

        // load vs step collision
        last = 4'd15; load = 1; in = 4'd4;
        cyc();
        check("coll_pre_idx", 32'(idx), 32'h4);
        in = 4'd12;
        cyc();
        load = 0;
        check("coll_idx", 32'(idx), 32'hC);
        check("coll_out", 32'(out), 32'h1000);
        check("coll_wrap", 32'(wrap), 32'h0);

        // last = 0 holds index 0 and pulses wrap every dwell+1 cycles
        last = 4'd0; dwell = 8'd1; load = 1; in = 4'd0;
        cyc();
        load = 0;
        check("l0_wrap_a", 32'(wrap), 32'h0);
        cyc();
        check("l0_wrap_b", 32'(wrap), 32'h0);
        cyc();
        check("l0_wrap_c", 32'(wrap), 32'h1);
        check("l0_out", 32'(out), 32'h1);
        cyc();
        check("l0_wrap_d", 32'(wrap), 32'h0);

        // leaving scan for direct decodes in on the next edge
        mode = 0; in = 4'd7;
        cyc();
        check("to_dir_out", 32'(out), 32'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
